multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle control unit that sequences the 8-bit datapath.
- Owns instruction fetch and data-memory handshakes, decodes the 16-bit instruction, and drives the datapath control signals one phase per cycle.
- Pulses pc_en once per retired instruction.
- Sits between the instruction/data memory interfaces and the datapath, replacing the static single-cycle control decode.

Parameters:
IWIDTH, 16, instruction width; opcode is instr[IWIDTH-1:IWIDTH-4], funct is instr[3:0]
TIMEOUT, 15, max cycles to wait for a memory ready before a bus error
RETW, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
imem_rdata  input  IWIDTH  fetched instruction word
imem_ready  input  1  fetch data valid this cycle
imem_req  output  1  fetch request
dmem_ready  input  1  data access complete this cycle
dmem_req  output  1  data access request
dmem_we  output  1  data access is a store
zero  input  1  datapath ALU zero flag
instr  output  IWIDTH  registered instruction (IR) driven to the datapath
memtoreg, branch, alusrc, regdst, regwrite, jump  output  1 each  datapath controls
alucontrol  output  4  ALU operation
pc_en  output  1  one-cycle PC update strobe
illegal  output  1  sticky illegal-opcode flag
bus_err  output  1  sticky memory-timeout flag
halted  output  1  high in HALT
retired  output  RETW  count of retired instructions

Behaviour:
- Reset (synchronous, active-high, wins over everything including mid-handshake):
  - state=FETCH, IR=0, retired=0, illegal=0, bus_err=0, wait counter=0.
  - All outputs 0 during the reset cycle.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are Moore outputs decoded from state and IR.
- Opcodes:
  - 0000 R-type: alucontrol=funct
  - 0001 LW
  - 0010 SW
  - 0011 BEQ
  - 0100 J
  - 1100 ADDI
  - 1111 HALT
  - others illegal
- FETCH:
  - imem_req=1 held until imem_ready.
  - On ready: IR<=imem_rdata, go to DECODE.
- DECODE:
  - J: jump=1, pc_en=1, retire, go to FETCH.
  - HALT: go to HALT.
  - Illegal: illegal<=1, pc_en=1, retire, go to FETCH (NOP semantics).
  - Else go to EXEC.
- EXEC:
  - alusrc=1 for ADDI/LW/SW, 0 for R/BEQ.
  - alucontrol: 0000 (add) for ADDI/LW/SW, 0001 (sub) for BEQ, funct for R.
  - BEQ: branch=1, pc_en=1, retire, go to FETCH. The datapath forms pcsrc from branch&zero.
  - LW/SW: go to MEM. R/ADDI: go to WB.
- MEM:
  - dmem_req=1 held until dmem_ready; dmem_we=1 for SW.
  - EXEC controls stay stable.
  - On ready: SW does pc_en=1, retire, FETCH; LW goes to WB.
- WB:
  - regwrite=1 and pc_en=1, retire, go to FETCH.
  - regdst=1 for R, else 0. memtoreg=1 for LW.
  - alusrc and alucontrol held at EXEC values.
- Latency with ready in first cycle:
  - J = 2 cycles
  - BEQ = 3 cycles
  - R/ADDI/SW = 4 cycles
  - LW = 5 cycles
- Each extra wait cycle adds 1.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each non-ready cycle.
  - Reaching TIMEOUT non-ready cycles sets bus_err<=1, drops the request and goes to HALT.
  - Ready arriving on the TIMEOUT-th cycle is accepted; no error.
- HALT: halted=1, all other controls 0; exits only by reset.
- retired:
  - Increments exactly on pc_en cycles and wraps at 2^RETW.
  - HALT and timeouts do not retire.
- Requests are never dropped before ready, except by reset or timeout.
- Ready without a request is ignored.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state enum
  - opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT)
  - ALU codes ALU_ADD=0000, ALU_SUB=0001
- One sub-module, mc_decode: combinational opcode → instruction class (is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_halt, is_illegal), instantiated on IR.

Test Plan:
- Reset held 3 cycles, then released; FETCH imem_rdata=1100001000000001 with ready on the first cycle → ADDI: EXEC alusrc=1, alucontrol=0000; WB regwrite=1, regdst=0, pc_en=1; retired=1 after 4 cycles.
- R-type 0000xxxxxxxx0110 → EXEC alucontrol=0110, alusrc=0; WB regdst=1, regwrite=1.
- LW with dmem_ready delayed 3 cycles → dmem_req held 4 cycles, dmem_we=0; WB memtoreg=1; total 8 cycles.
- SW → dmem_we=1 in MEM, regwrite never asserted, pc_en with ready. BEQ → branch=1, alucontrol=0001, pc_en=1 in cycle 3.
- J → jump=1, pc_en=1 in DECODE. Opcode 0111 → illegal=1 sticky, pc_en=1. Opcode 1111 → halted=1, no pc_en.
- imem_ready held low with TIMEOUT=15 → bus_err=1 after 15 cycles, halted=1. Reset asserted mid-MEM → next cycle state FETCH, all flags cleared, dmem_req=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit:
// FSM states, opcode values and the ALU operation codes the controller emits itself.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_J    = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction- and data-memory handshake bundle.
// The controller is the master and issues the requests; the memory side is the slave.
interface multicycle_controller_if #(
  parameter int IWIDTH = 16
);
  logic [IWIDTH-1:0] imem_rdata;
  logic              imem_ready;
  logic              imem_req;
  logic              dmem_ready;
  logic              dmem_req;
  logic              dmem_we;

  modport master (
    input  imem_rdata, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we
  );

  modport slave (
    output imem_rdata, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we
  );
endinterface

// File: rtl/mc_decode.sv
// Opcode classifier: turns the 4-bit opcode into one-hot instruction class flags.
module mc_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_r,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_addi,
  output logic       is_halt,
  output logic       is_illegal
);

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_addi = (opcode == OP_ADDI);
  assign is_halt = (opcode == OP_HALT);
  assign is_illegal = !(is_r || is_lw || is_sw || is_beq || is_j || is_addi || is_halt);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: fetches into IR, decodes, and sequences the datapath one phase
// per cycle, with bounded memory waits, sticky error flags and a retired-instruction counter.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int IWIDTH  = 16,
  parameter int TIMEOUT = 15,
  parameter int RETW    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.master mem,
  input  logic                  zero,
  output logic [IWIDTH-1:0]     instr,
  output logic                  memtoreg,
  output logic                  branch,
  output logic                  alusrc,
  output logic                  regdst,
  output logic                  regwrite,
  output logic                  jump,
  output logic [3:0]            alucontrol,
  output logic                  pc_en,
  output logic                  illegal,
  output logic                  bus_err,
  output logic                  halted,
  output logic [RETW-1:0]       retired
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t            state;
  logic [IWIDTH-1:0] ir;
  logic [RETW-1:0]   retired_q;
  logic              illegal_q;
  logic              bus_err_q;
  logic [WW-1:0]     wait_cnt;

  logic is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_halt, is_illegal;
  logic imem_req_c, dmem_req_c, dmem_we_c;

  // The branch decision is taken in the datapath (branch & zero), so the flag is not consumed here.
  logic unused_zero;
  assign unused_zero = zero;

  mc_decode u_decode (
    .opcode     (ir[IWIDTH-1 -: 4]),
    .is_r       (is_r),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_j       (is_j),
    .is_addi    (is_addi),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (pc_en) retired_q <= retired_q + 1'b1;
      case (state)
        S_FETCH: begin
          if (mem.imem_ready) begin
            ir       <= mem.imem_rdata;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_err_q <= 1'b1;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (is_j) state <= S_FETCH;
          else if (is_halt) state <= S_HALT;
          else if (is_illegal) begin
            illegal_q <= 1'b1;
            state     <= S_FETCH;
          end else state <= S_EXEC;
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_beq) state <= S_FETCH;
          else if (is_lw || is_sw) state <= S_MEM;
          else state <= S_WB;
        end
        S_MEM: begin
          if (mem.dmem_ready) begin
            wait_cnt <= '0;
            state    <= is_sw ? S_FETCH : S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_err_q <= 1'b1;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Outputs come from state and IR only (plus the memory ready that closes a store); reset forces all to 0.
  always_comb begin
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    instr      = '0;
    memtoreg   = 1'b0;
    branch     = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    jump       = 1'b0;
    alucontrol = ALU_ADD;
    pc_en      = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    halted     = 1'b0;
    retired    = '0;
    if (!reset) begin
      instr   = ir;
      illegal = illegal_q;
      bus_err = bus_err_q;
      retired = retired_q;
      case (state)
        S_FETCH: imem_req_c = 1'b1;
        S_DECODE: begin
          jump  = is_j;
          pc_en = is_j || is_illegal;
        end
        S_EXEC: begin
          alusrc     = is_addi || is_lw || is_sw;
          alucontrol = is_r ? ir[3:0] : (is_beq ? ALU_SUB : ALU_ADD);
          branch     = is_beq;
          pc_en      = is_beq;
        end
        S_MEM: begin
          alusrc     = 1'b1;
          alucontrol = ALU_ADD;
          dmem_req_c = 1'b1;
          dmem_we_c  = is_sw;
          pc_en      = is_sw && mem.dmem_ready;
        end
        S_WB: begin
          alusrc     = is_addi || is_lw;
          alucontrol = is_r ? ir[3:0] : ALU_ADD;
          regwrite   = 1'b1;
          regdst     = is_r;
          memtoreg   = is_lw;
          pc_en      = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign mem.dmem_we  = dmem_we_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a phase-timeline model predicts every output each
// cycle, and literal pins on selected fields anchor the model to hand-computed values.
module tb_multicycle_controller;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        memtoreg;
    logic        branch;
    logic        alusrc;
    logic        regdst;
    logic        regwrite;
    logic        jump;
    logic        pc_en;
    logic        illegal;
    logic        bus_err;
    logic        halted;
    logic [3:0]  alucontrol;
    logic [15:0] instr;
    logic [15:0] retired;
  } obs_t;

  typedef enum int {P_FETCH, P_DEC, P_EXEC, P_MEM, P_WB, P_HALT, P_RESET} phase_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        zero;
  logic [15:0] instr;
  logic        memtoreg, branch, alusrc, regdst, regwrite, jump, pc_en;
  logic        illegal, bus_err, halted;
  logic [3:0]  alucontrol;
  logic [15:0] retired;

  multicycle_controller_if #(.IWIDTH(16)) bus ();

  multicycle_controller #(.IWIDTH(16), .TIMEOUT(15), .RETW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus),
    .zero       (zero),
    .instr      (instr),
    .memtoreg   (memtoreg),
    .branch     (branch),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .jump       (jump),
    .alucontrol (alucontrol),
    .pc_en      (pc_en),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  obs_t dutObs;
  assign dutObs = {bus.imem_req, bus.dmem_req, bus.dmem_we, memtoreg, branch, alusrc, regdst,
                   regwrite, jump, pc_en, illegal, bus_err, halted, alucontrol, instr, retired};

  // Abstract architectural state the model keeps: IR, counter and sticky flags.
  logic [15:0] modelIr;
  logic [15:0] modelRetired;
  logic        modelIllegal;
  logic        modelBusErr;

  obs_t   expObs;
  obs_t   curPinMask, curPinVal;
  obs_t   pinMask [0:6];
  obs_t   pinVal  [0:6];
  phase_t curPhase;
  logic   expValid = 1'b0;
  int     checks = 0;
  int     failures = 0;

  function automatic obs_t expOut(phase_t ph, logic dRdy);
    obs_t e = '0;
    logic [3:0] op = modelIr[15:12];
    logic [3:0] fn = modelIr[3:0];
    logic isR = (op == 4'h0), isLw = (op == 4'h1), isSw = (op == 4'h2), isBeq = (op == 4'h3);
    logic isJ = (op == 4'h4), isAddi = (op == 4'hC), isHalt = (op == 4'hF);
    logic isIll = !(isR || isLw || isSw || isBeq || isJ || isAddi || isHalt);
    if (ph == P_RESET) return e;
    e.instr   = modelIr;
    e.retired = modelRetired;
    e.illegal = modelIllegal;
    e.bus_err = modelBusErr;
    case (ph)
      P_FETCH: e.imem_req = 1'b1;
      P_DEC: begin
        e.jump  = isJ;
        e.pc_en = isJ || isIll;
      end
      P_EXEC: begin
        e.alusrc     = isAddi || isLw || isSw;
        e.alucontrol = isR ? fn : (isBeq ? 4'b0001 : 4'b0000);
        e.branch     = isBeq;
        e.pc_en      = isBeq;
      end
      P_MEM: begin
        e.alusrc   = 1'b1;
        e.dmem_req = 1'b1;
        e.dmem_we  = isSw;
        e.pc_en    = isSw && dRdy;
      end
      P_WB: begin
        e.regwrite   = 1'b1;
        e.pc_en      = 1'b1;
        e.regdst     = isR;
        e.memtoreg   = isLw;
        e.alusrc     = isAddi || isLw;
        e.alucontrol = isR ? fn : 4'b0000;
      end
      default: e.halted = 1'b1;
    endcase
    return e;
  endfunction

  // Single compare process: full model check each cycle, plus any literal pin armed for the phase.
  always @(negedge clk) begin
    if (expValid) begin
      checks++;
      if (dutObs !== expObs) begin
        failures++;
        $display("[TB] FAIL model_%s at %0t: got=%h want=%h", curPhase.name(), $time, dutObs, expObs);
      end
      if (curPinMask != '0) begin
        checks++;
        if ((dutObs & curPinMask) !== curPinVal) begin
          failures++;
          $display("[TB] FAIL pin_%s at %0t: got=%h want=%h", curPhase.name(), $time,
                   dutObs & curPinMask, curPinVal);
        end
      end
    end
  end

  task automatic runCycle(input phase_t ph, input logic iRdy, input logic dRdy);
    reset            = (ph == P_RESET);
    bus.imem_ready   = iRdy;
    bus.dmem_ready   = dRdy;
    expObs           = expOut(ph, dRdy);
    curPhase         = ph;
    curPinMask       = pinMask[int'(ph)];
    curPinVal        = pinVal[int'(ph)];
    expValid         = 1'b1;
    @(posedge clk);
    #1;
    if (ph == P_RESET) begin
      modelIr      = '0;
      modelRetired = '0;
      modelIllegal = 1'b0;
      modelBusErr  = 1'b0;
    end else if (expObs.pc_en) begin
      modelRetired = modelRetired + 16'd1;
    end
  endtask

  task automatic armPin(input phase_t ph, input obs_t m, input obs_t v);
    pinMask[int'(ph)] = m;
    pinVal[int'(ph)]  = v;
  endtask

  task automatic clearPins();
    for (int k = 0; k < 7; k++) begin
      pinMask[k] = '0;
      pinVal[k]  = '0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word, input int fw, input int mw);
    logic [3:0] op = word[15:12];
    for (int i = 0; i <= fw; i++) begin
      bus.imem_rdata = (i == fw) ? word : 16'($urandom);
      runCycle(P_FETCH, i == fw, 1'b0);
    end
    modelIr = word;
    bus.imem_rdata = 16'($urandom);
    runCycle(P_DEC, 1'b0, 1'b1);
    if (op == 4'hF) begin
      for (int k = 0; k < 3; k++) runCycle(P_HALT, 1'b1, 1'b1);
      return;
    end
    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC})) modelIllegal = 1'b1;
    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hC})) return;
    runCycle(P_EXEC, 1'b1, 1'b0);
    if (op == 4'h3) return;
    if (op == 4'h1 || op == 4'h2) begin
      for (int j = 0; j <= mw; j++) runCycle(P_MEM, 1'b0, j == mw);
      if (op == 4'h2) return;
    end
    runCycle(P_WB, 1'b0, 1'b0);
  endtask

  obs_t m, v;

  initial begin
    reset = 1'b1;
    zero = 1'b0;
    bus.imem_rdata = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    modelIr = '0; modelRetired = '0; modelIllegal = 1'b0; modelBusErr = 1'b0;
    clearPins();

    for (int k = 0; k < 3; k++) runCycle(P_RESET, 1'b1, 1'b1);

    // ADDI, ready on first cycle.
    m = '0; v = '0; m.alusrc = 1; v.alusrc = 1; m.alucontrol = '1; v.alucontrol = 4'b0000;
    armPin(P_EXEC, m, v);
    m = '0; v = '0; m.regwrite = 1; v.regwrite = 1; m.regdst = 1; m.pc_en = 1; v.pc_en = 1;
    armPin(P_WB, m, v);
    applyStimulus(16'b1100001000000001, 0, 0);
    clearPins();
    m = '0; v = '0; m.retired = '1; v.retired = 16'd1; m.instr = '1; v.instr = 16'hC201;
    armPin(P_FETCH, m, v);
    runCycle(P_FETCH, 1'b0, 1'b0);
    clearPins();

    // R-type funct 0110 with one fetch wait.
    m = '0; v = '0; m.alucontrol = '1; v.alucontrol = 4'b0110; m.alusrc = 1;
    armPin(P_EXEC, m, v);
    m = '0; v = '0; m.regdst = 1; v.regdst = 1; m.regwrite = 1; v.regwrite = 1;
    armPin(P_WB, m, v);
    applyStimulus(16'h0A36, 1, 0);
    clearPins();

    // LW with data ready delayed 3 cycles.
    m = '0; v = '0; m.dmem_req = 1; v.dmem_req = 1; m.dmem_we = 1;
    armPin(P_MEM, m, v);
    m = '0; v = '0; m.memtoreg = 1; v.memtoreg = 1;
    armPin(P_WB, m, v);
    applyStimulus(16'h1234, 0, 3);
    clearPins();

    // SW with 2 waits.
    m = '0; v = '0; m.dmem_we = 1; v.dmem_we = 1; m.regwrite = 1;
    armPin(P_MEM, m, v);
    applyStimulus(16'h2345, 0, 2);
    clearPins();

    // BEQ.
    zero = 1'b1;
    m = '0; v = '0; m.branch = 1; v.branch = 1; m.alucontrol = '1; v.alucontrol = 4'b0001;
    m.pc_en = 1; v.pc_en = 1;
    armPin(P_EXEC, m, v);
    applyStimulus(16'h3001, 0, 0);
    clearPins();
    zero = 1'b0;

    // J.
    m = '0; v = '0; m.jump = 1; v.jump = 1; m.pc_en = 1; v.pc_en = 1; m.retired = '1; v.retired = 16'd5;
    armPin(P_DEC, m, v);
    applyStimulus(16'h4ABC, 0, 0);
    clearPins();

    // Illegal opcode 0111.
    m = '0; v = '0; m.pc_en = 1; v.pc_en = 1; m.illegal = 1;
    armPin(P_DEC, m, v);
    applyStimulus(16'h7000, 0, 0);
    clearPins();

    // Ready on the TIMEOUT-th cycle is accepted, both for fetch and for a store.
    m = '0; v = '0; m.illegal = 1; v.illegal = 1; m.bus_err = 1;
    armPin(P_FETCH, m, v);
    applyStimulus(16'hC00F, 14, 0);
    applyStimulus(16'h2001, 0, 14);
    clearPins();

    // Fetch timeout: 15 cycles without ready.
    for (int k = 0; k < 15; k++) begin
      bus.imem_rdata = 16'($urandom);
      runCycle(P_FETCH, 1'b0, 1'b0);
    end
    modelBusErr = 1'b1;
    m = '0; v = '0; m.halted = 1; v.halted = 1; m.bus_err = 1; v.bus_err = 1; m.imem_req = 1;
    armPin(P_HALT, m, v);
    for (int k = 0; k < 3; k++) runCycle(P_HALT, 1'b1, 1'b0);
    clearPins();

    // Reset in the middle of a load's memory wait.
    for (int k = 0; k < 2; k++) runCycle(P_RESET, 1'b0, 1'b0);
    bus.imem_rdata = 16'h1111;
    runCycle(P_FETCH, 1'b1, 1'b0);
    modelIr = 16'h1111;
    runCycle(P_DEC, 1'b0, 1'b0);
    runCycle(P_EXEC, 1'b0, 1'b0);
    runCycle(P_MEM, 1'b0, 1'b0);
    runCycle(P_MEM, 1'b0, 1'b0);
    runCycle(P_RESET, 1'b0, 1'b0);
    m = '0; v = '0; m.imem_req = 1; v.imem_req = 1; m.dmem_req = 1; m.bus_err = 1; m.instr = '1;
    armPin(P_FETCH, m, v);
    runCycle(P_FETCH, 1'b0, 1'b1);
    clearPins();

    // HALT opcode: no retire, halted stays high.
    m = '0; v = '0; m.halted = 1; v.halted = 1; m.pc_en = 1; m.retired = '1; v.retired = 16'd0;
    armPin(P_HALT, m, v);
    applyStimulus(16'hF000, 0, 0);
    clearPins();

    expValid = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
